// File: rtl/max_scan_engine_if.sv
// rtl/max_scan_engine_if.sv - memory-port and control bundle of the max scan engine
interface max_scan_engine_if;
    logic        start;
    logic [31:0] memOut;
    logic [31:0] adr;
    logic [31:0] inputData;
    logic        MemRead;
    logic        MemWrite;
    logic        busy;
    logic        done;
    logic [31:0] maxValue;
    logic [31:0] maxIndex;

    modport master (
        input  start, memOut,
        output adr, inputData, MemRead, MemWrite, busy, done, maxValue, maxIndex
    );

    modport slave (
        output start, memOut,
        input  adr, inputData, MemRead, MemWrite, busy, done, maxValue, maxIndex
    );
endinterface

// File: rtl/max_scan_engine.sv
// rtl/max_scan_engine.sv - scans COUNT words for the maximum and writes value/index back to memory
// Optional MAX_SCAN_SIGNED_EN switches the comparison to two's-complement signed.
module max_scan_engine #(
    parameter logic [31:0] BASE_ADR = 32'd1000,
    parameter int unsigned COUNT    = 20,
    parameter logic [31:0] VAL_ADR  = 32'd2000,
    parameter logic [31:0] IDX_ADR  = 32'd2004
) (
    input  logic             clk,
    input  logic             rst,
    max_scan_engine_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WRITE_VAL,
        WRITE_IDX,
        DONE
    } stateT;

    localparam logic [15:0] LAST_PTR = 16'(COUNT - 1);

    stateT       state;
    stateT       nextState;
    logic [15:0] ptr;
    logic [31:0] curMax;
    logic [15:0] curIdx;
    logic [31:0] maxValueQ;
    logic [31:0] maxIndexQ;
    logic        isGreater;

`ifdef MAX_SCAN_SIGNED_EN
    assign isGreater = $signed(bus.memOut) > $signed(curMax);
`else
    assign isGreater = bus.memOut > curMax;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            curMax    <= '0;
            curIdx    <= '0;
            maxValueQ <= '0;
            maxIndexQ <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ptr <= '0;
                    end
                end
                SCAN: begin
                    // Element 0 seeds the running maximum; strict compare keeps the first tie.
                    if (ptr == 16'd0 || isGreater) begin
                        curMax <= bus.memOut;
                        curIdx <= ptr;
                    end
                    ptr <= ptr + 16'd1;
                end
                DONE: begin
                    maxValueQ <= curMax;
                    maxIndexQ <= {16'd0, curIdx};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState     = state;
        bus.adr       = '0;
        bus.inputData = '0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = SCAN;
                end
            end
            SCAN: begin
                bus.MemRead = 1'b1;
                bus.adr     = BASE_ADR + {14'd0, ptr, 2'b00};
                if (ptr == LAST_PTR) begin
                    nextState = WRITE_VAL;
                end
            end
            WRITE_VAL: begin
                bus.MemWrite  = 1'b1;
                bus.adr       = VAL_ADR;
                bus.inputData = curMax;
                nextState     = WRITE_IDX;
            end
            WRITE_IDX: begin
                bus.MemWrite  = 1'b1;
                bus.adr       = IDX_ADR;
                bus.inputData = {16'd0, curIdx};
                nextState     = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state == SCAN) || (state == WRITE_VAL) || (state == WRITE_IDX);
    assign bus.done     = (state == DONE);
    assign bus.maxValue = maxValueQ;
    assign bus.maxIndex = maxIndexQ;
endmodule

// File: tb/tb_max_scan_engine.sv
// tb/tb_max_scan_engine.sv - directed self-checking bench for max_scan_engine
module tb_max_scan_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    max_scan_engine_if ifc();
    max_scan_engine_if ifc1();

    max_scan_engine dut (.clk(clk), .rst(rst), .bus(ifc));
    max_scan_engine #(.COUNT(1), .VAL_ADR(32'd3000), .IDX_ADR(32'd3004))
        dut1 (.clk(clk), .rst(rst), .bus(ifc1));

    logic [31:0] mem [0:1023];
    logic        pokeEn = 1'b0;
    logic [9:0]  pokeIdx = '0;
    logic [31:0] pokeData = '0;

    assign ifc.memOut  = mem[ifc.adr[11:2]];
    assign ifc1.memOut = mem[ifc1.adr[11:2]];

    always @(posedge clk) begin
        if (pokeEn) mem[pokeIdx] <= pokeData;
        if (ifc.MemWrite) mem[ifc.adr[11:2]] <= ifc.inputData;
        if (ifc1.MemWrite) mem[ifc1.adr[11:2]] <= ifc1.inputData;
    end

    int checks = 0;
    int errors = 0;
    int cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        pokeEn = 1'b1;
        pokeIdx = 10'(idx);
        pokeData = data;
        tick();
        pokeEn = 1'b0;
    endtask

    // Pulses start and advances until done is seen; cyc is the cycle number (start edge ends cycle 0).
    task automatic runToDone();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        cyc = 1;
        while (ifc.done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h exp 0", ifc.done); end
        checks++; if (ifc.maxValue !== 32'd0 || ifc.maxIndex !== 32'd0) begin errors++; $display("FAIL reset_max got %0h/%0h exp 0/0", ifc.maxValue, ifc.maxIndex); end
        checks++; if (ifc.adr !== 32'd0 || ifc.inputData !== 32'd0 || ifc.MemRead !== 1'b0 || ifc.MemWrite !== 1'b0) begin
            errors++; $display("FAIL reset_bus got adr %0h data %0h rd %0h wr %0h exp all 0", ifc.adr, ifc.inputData, ifc.MemRead, ifc.MemWrite); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_count_one();
        poke(250, 32'h1234);
        ifc1.start = 1'b1;
        tick();
        ifc1.start = 1'b0;
        cyc = 1;
        checks++; if (ifc1.MemRead !== 1'b1 || ifc1.adr !== 32'd1000) begin errors++; $display("FAIL c1_scan got rd %0h adr %0d exp 1 1000", ifc1.MemRead, ifc1.adr); end
        while (ifc1.done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL c1_done_cycle got %0d exp 4", cyc); end
        tick();
        checks++; if (ifc1.maxValue !== 32'h1234 || ifc1.maxIndex !== 32'd0) begin errors++; $display("FAIL c1_result got %0h/%0h exp 1234/0", ifc1.maxValue, ifc1.maxIndex); end
        checks++; if (mem[750] !== 32'h1234 || mem[751] !== 32'd0) begin errors++; $display("FAIL c1_mem got %0h/%0h exp 1234/0", mem[750], mem[751]); end
    endtask

    task automatic test_ascending();
        for (int i = 0; i < 20; i++) poke(250 + i, 32'(i + 1));
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        cyc = 1;
        checks++; if (ifc.MemRead !== 1'b1 || ifc.adr !== 32'd1000 || ifc.busy !== 1'b1) begin
            errors++; $display("FAIL asc_first_read got rd %0h adr %0d busy %0h exp 1 1000 1", ifc.MemRead, ifc.adr, ifc.busy); end
        while (ifc.done !== 1'b1 && cyc < 60) begin
            if (cyc == 20) begin
                checks++; if (ifc.adr !== 32'd1076) begin errors++; $display("FAIL asc_last_read got %0d exp 1076", ifc.adr); end
            end
            if (cyc == 21) begin
                checks++; if (ifc.MemWrite !== 1'b1 || ifc.MemRead !== 1'b0 || ifc.adr !== 32'd2000 || ifc.inputData !== 32'd20) begin
                    errors++; $display("FAIL asc_write_val got wr %0h rd %0h adr %0d data %0d exp 1 0 2000 20", ifc.MemWrite, ifc.MemRead, ifc.adr, ifc.inputData); end
            end
            if (cyc == 22) begin
                checks++; if (ifc.MemWrite !== 1'b1 || ifc.adr !== 32'd2004 || ifc.inputData !== 32'd19) begin
                    errors++; $display("FAIL asc_write_idx got wr %0h adr %0d data %0d exp 1 2004 19", ifc.MemWrite, ifc.adr, ifc.inputData); end
            end
            tick();
            cyc++;
        end
        checks++; if (cyc !== 23) begin errors++; $display("FAIL asc_done_cycle got %0d exp 23", cyc); end
        checks++; if (ifc.maxValue !== 32'd0) begin errors++; $display("FAIL asc_hold_in_done got %0h exp 0", ifc.maxValue); end
        tick();
        checks++; if (ifc.maxValue !== 32'd20 || ifc.maxIndex !== 32'd19) begin errors++; $display("FAIL asc_result got %0d/%0d exp 20/19", ifc.maxValue, ifc.maxIndex); end
        checks++; if (mem[500] !== 32'd20 || mem[501] !== 32'd19) begin errors++; $display("FAIL asc_mem got %0d/%0d exp 20/19", mem[500], mem[501]); end
        checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin errors++; $display("FAIL asc_idle got busy %0h done %0h exp 0 0", ifc.busy, ifc.done); end
    endtask

    task automatic test_duplicate();
        for (int i = 0; i < 20; i++) poke(250 + i, (i == 7) ? 32'd50 : 32'(50 - i));
        runToDone();
        tick();
        checks++; if (ifc.maxValue !== 32'd50 || ifc.maxIndex !== 32'd0) begin errors++; $display("FAIL dup_result got %0d/%0d exp 50/0", ifc.maxValue, ifc.maxIndex); end
    endtask

    task automatic test_negative();
        logic [31:0] expVal;
        logic [31:0] expIdx;
`ifdef MAX_SCAN_SIGNED_EN
        expVal = 32'd10;
        expIdx = 32'd0;
`else
        expVal = 32'hFFFF_FFFF;
        expIdx = 32'd3;
`endif
        for (int i = 0; i < 20; i++) poke(250 + i, (i == 3) ? 32'hFFFF_FFFF : 32'd10);
        runToDone();
        checks++; if (cyc !== 23) begin errors++; $display("FAIL neg_done_cycle got %0d exp 23", cyc); end
        tick();
        checks++; if (ifc.maxValue !== expVal || ifc.maxIndex !== expIdx) begin errors++; $display("FAIL neg_result got %0h/%0h exp %0h/%0h", ifc.maxValue, ifc.maxIndex, expVal, expIdx); end
        checks++; if (mem[500] !== expVal || mem[501] !== expIdx) begin errors++; $display("FAIL neg_mem got %0h/%0h exp %0h/%0h", mem[500], mem[501], expVal, expIdx); end
    endtask

    task automatic test_reset_mid_scan();
        int writes = 0;
        poke(500, 32'hAAAA);
        poke(501, 32'hBBBB);
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin tick(); cyc++; end
        rst = 1'b1;
        ifc.start = 1'b1;
        tick();
        rst = 1'b0;
        ifc.start = 1'b0;
        checks++; if (ifc.busy !== 1'b0 || ifc.MemRead !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got busy %0h rd %0h exp 0 0", ifc.busy, ifc.MemRead); end
        checks++; if (ifc.maxValue !== 32'd0 || ifc.maxIndex !== 32'd0) begin errors++; $display("FAIL rst_mid_max got %0h/%0h exp 0/0", ifc.maxValue, ifc.maxIndex); end
        for (int i = 0; i < 30; i++) begin
            if (ifc.MemWrite === 1'b1 || ifc.busy === 1'b1) writes++;
            tick();
        end
        checks++; if (writes !== 0) begin errors++; $display("FAIL rst_mid_activity got %0d exp 0", writes); end
        checks++; if (mem[500] !== 32'hAAAA || mem[501] !== 32'hBBBB) begin errors++; $display("FAIL rst_mid_mem got %0h/%0h exp aaaa/bbbb", mem[500], mem[501]); end
    endtask

    task automatic test_start_while_busy();
        int doneCount = 0;
        int firstDone = 0;
        ifc.start = 1'b1;
        tick();
        cyc = 1;
        while (cyc < 50) begin
            ifc.start = (cyc == 5) ? 1'b1 : 1'b0;
            if (ifc.done === 1'b1) begin
                doneCount++;
                if (firstDone == 0) firstDone = cyc;
            end
            tick();
            cyc++;
        end
        ifc.start = 1'b0;
        checks++; if (doneCount !== 1 || firstDone !== 23) begin errors++; $display("FAIL busy_start got %0d dones first %0d exp 1 at 23", doneCount, firstDone); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] firstVal;
        firstVal = ifc.maxValue;
        runToDone();
        // In DONE: start must be ignored; element 3 is replaced for the second run.
        ifc.start = 1'b1;
        pokeEn = 1'b1;
        pokeIdx = 10'd253;
        pokeData = 32'd99;
        tick();
        pokeEn = 1'b0;
        checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin errors++; $display("FAIL b2b_done_start got busy %0h done %0h exp 0 0", ifc.busy, ifc.done); end
        tick();
        ifc.start = 1'b0;
        cyc = 1;
        while (ifc.done !== 1'b1 && cyc < 60) begin
            if (cyc == 10) begin
                checks++; if (ifc.maxValue !== firstVal) begin errors++; $display("FAIL b2b_hold got %0h exp %0h", ifc.maxValue, firstVal); end
            end
            tick();
            cyc++;
        end
        checks++; if (cyc !== 23) begin errors++; $display("FAIL b2b_done_cycle got %0d exp 23", cyc); end
        tick();
        checks++; if (ifc.maxValue !== 32'd99 || ifc.maxIndex !== 32'd3) begin errors++; $display("FAIL b2b_result got %0h/%0h exp 63/3", ifc.maxValue, ifc.maxIndex); end
        checks++; if (mem[500] !== 32'd99 || mem[501] !== 32'd3) begin errors++; $display("FAIL b2b_mem got %0h/%0h exp 63/3", mem[500], mem[501]); end
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc1.start = 1'b0;
        test_reset();
        test_count_one();
        test_ascending();
        test_duplicate();
        test_negative();
        test_reset_mid_scan();
        test_start_while_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/max_scan_engine.md
# max_scan_engine

Memory-side scan engine that sits directly upstream of the data memory's read/write port. On a start pulse it reads COUNT consecutive 32-bit words from BASE_ADR, tracks the maximum value and its element index, then writes the value to byte address VAL_ADR and the index to IDX_ADR. This lets the data memory's fixed max-value and max-index taps be filled in hardware, without a software loop on the single-cycle CPU. While busy is high, a system-level mux gives this block ownership of the memory port.

## Interface
Parameters:
- BASE_ADR, 1000: byte address of element 0; word-aligned.
- COUNT, 20: number of elements scanned; legal range 1..65535.
- VAL_ADR, 2000: byte address where the maximum value is written.
- IDX_ADR, 2004: byte address where the maximum's element index is written.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- memOut  input  32  combinational read data from the data memory (its outputData).
- adr  output  32  byte address to the data memory.
- inputData  output  32  write data to the data memory.
- MemRead  output  1  read enable.
- MemWrite  output  1  write enable; the memory commits on the rising edge.
- busy  output  1  high in SCAN, WRITE_VAL and WRITE_IDX.
- done  output  1  one-cycle completion pulse.
- maxValue  output  32  registered maximum from the last completed scan.
- maxIndex  output  32  registered 0-based index from the last completed scan, zero-extended.

## Operation
- States are IDLE, SCAN, WRITE_VAL, WRITE_IDX and DONE; state encoding is free.
- IDLE
  - adr, inputData, MemRead and MemWrite are all 0.
  - start=1 moves to SCAN and clears ptr to 0.
- SCAN
  - Drives MemRead=1 and adr=BASE_ADR + 4*ptr; memOut is consumed in the same cycle.
  - ptr==0: loads curMax=memOut and curIdx=0 unconditionally.
  - ptr>0: if memOut > curMax, loads curMax=memOut and curIdx=ptr. Comparison is strict, so on ties the first occurrence wins.
  - ptr increments every cycle. After the cycle with ptr==COUNT-1, moves to WRITE_VAL.
- WRITE_VAL: MemWrite=1, MemRead=0, adr=VAL_ADR, inputData=curMax.
- WRITE_IDX: MemWrite=1, adr=IDX_ADR, inputData=curIdx.
- DONE
  - done=1; maxValue and maxIndex load curMax and curIdx on the exiting edge.
  - Returns to IDLE unconditionally; start in this cycle is ignored.
- start is ignored in every state other than IDLE; there is no queuing.
- Arithmetic: ptr is 16 bits and adr is computed modulo 2^32. An address past the memory is the integrator's error and is not checked here.

## Timing
- Reset values:
  - state=IDLE, ptr=0, curMax=0, curIdx=0.
  - busy=0, done=0, maxValue=0, maxIndex=0.
  - adr, inputData, MemRead and MemWrite all 0.
- start sampled high at edge E0:
  - SCAN occupies cycles 1..COUNT.
  - WRITE_VAL is cycle COUNT+1 and WRITE_IDX is cycle COUNT+2.
  - done is high during cycle COUNT+3.
  - The next start is accepted at the edge ending cycle COUNT+4 or later; the block is in IDLE from cycle COUNT+4.
- Memory contents at VAL_ADR are updated at the edge ending cycle COUNT+1, and at IDX_ADR at the edge ending cycle COUNT+2.
- maxValue and maxIndex change only at the edge ending DONE; they hold their values across later scans until those scans complete.
- COUNT=1: one SCAN cycle; the result is element 0 with index 0.
- rst=1 in any state: IDLE on the next edge and all registers reset.
  - A write already committed by the memory remains in memory.
  - No further writes are issued.
  - maxValue and maxIndex return to 0.
- rst and start high in the same cycle: reset wins.

## Configuration
- MAX_SCAN_SIGNED_EN
  - Defined: the comparison treats memOut and curMax as two's-complement signed, so 32'hFFFFFFFF (-1) is smaller than 32'd5.
  - Undefined: the comparison is unsigned, so 32'hFFFFFFFF is the maximum.
  - No other behaviour changes.

## Test plan
All scenarios use defaults unless stated.
- Ascending data: preload mem[250..269] = 1..20, pulse start -> done in cycle 23; mem[500]=20, mem[501]=19, maxValue=20, maxIndex=19.
- Descending data with a duplicate: data 50,49,…, with 50 also at element 7 -> maxIndex=0 (first occurrence), maxValue=50.
- Negative values: element 3 = 32'hFFFFFFFF, all others 10 -> with MAX_SCAN_SIGNED_EN: value 10, index 0; without: value 32'hFFFFFFFF, index 3.
- Reset mid-scan: assert rst in cycle 10 -> IDLE next cycle; busy=0, maxValue=0, and mem[500] and mem[501] are unchanged from their preload.
- start while busy: pulse start at cycle 5 of a scan -> no restart; exactly one done, at cycle 23.
- Back-to-back: start in DONE is ignored; start in the following IDLE cycle produces a second done 23 cycles later with updated results after the data is changed between runs.
